// File: rtl/shift_row_stage.sv
// shift_row_stage: AES ShiftRows / InvShiftRows pipeline stage with a
// two-entry output FIFO and a delivered-block counter.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 asynchronous active-low reset
//   shiftRow_valid_in   upstream block valid
//   shiftRow_data_in    128-bit state from the previous stage
//   shiftRow_inv_in     1 = InvShiftRows, 0 = ShiftRows (sampled with data)
//   shiftRow_ready_out  stage can accept a block this cycle
//   shiftRow_flush_in   synchronous discard of every buffered block
//   shiftRow_data_out   shifted state at the FIFO head
//   shiftRow_valid_out  shiftRow_data_out holds a valid block
//   shiftRow_ready_in   downstream accepts the head block
//   shiftRow_count_out  blocks delivered downstream, wrapping 16-bit count
module shift_row_stage #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shiftRow_valid_in,
  input  logic [DATA_WIDTH-1:0] shiftRow_data_in,
  input  logic                  shiftRow_inv_in,
  output logic                  shiftRow_ready_out,
  input  logic                  shiftRow_flush_in,
  output logic [DATA_WIDTH-1:0] shiftRow_data_out,
  output logic                  shiftRow_valid_out,
  input  logic                  shiftRow_ready_in,
  output logic [15:0]           shiftRow_count_out
);

  logic [DATA_WIDTH-1:0] fwd;
  logic [DATA_WIDTH-1:0] inv;
  logic [DATA_WIDTH-1:0] shifted;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic [15:0]           count;

  logic push;
  logic pop;

  // Byte k sits at data[127-8k -: 8]; state cell s[r][c] is byte r+4c.
  // Every byte move is a constant wire, so the permutation costs no logic.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign fwd[DATA_WIDTH-1-8*(r+4*c) -: 8] =
        shiftRow_data_in[DATA_WIDTH-1-8*(r+4*((c+r)%4)) -: 8];
      assign inv[DATA_WIDTH-1-8*(r+4*c) -: 8] =
        shiftRow_data_in[DATA_WIDTH-1-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end

  assign shifted = shiftRow_inv_in ? inv : fwd;

  // Handshake flags come from registered occupancy only.
  assign shiftRow_ready_out = (occ < 2'(FIFO_DEPTH));
  assign shiftRow_valid_out = (occ != 2'd0);
  assign shiftRow_data_out  = mem[rd_ptr];
  assign shiftRow_count_out = count;

  assign push = shiftRow_valid_in & shiftRow_ready_out & ~shiftRow_flush_in;
  assign pop  = shiftRow_valid_out & shiftRow_ready_in & ~shiftRow_flush_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
      count  <= '0;
    end else if (shiftRow_flush_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        count  <= count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/shift_row_stage.md
SHIFT_ROW_STAGE -- requirements
Module: shift_row_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, state width in bits; only 128 is supported.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries; only 2 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port shiftRow_valid_in  input  1  upstream (subByte) block valid.
REQ-006 SHALL have port shiftRow_data_in  input  128  state from subByte.
REQ-007 SHALL have port shiftRow_inv_in  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with data.
REQ-008 SHALL have port shiftRow_ready_out  output  1  stage can accept a block this cycle.
REQ-009 SHALL have port shiftRow_flush_in  input  1  synchronous discard of all buffered blocks.
REQ-010 SHALL have port shiftRow_data_out  output  128  shifted state at FIFO head.
REQ-011 SHALL have port shiftRow_valid_out  output  1  shiftRow_data_out holds a valid block.
REQ-012 SHALL have port shiftRow_ready_in  input  1  downstream (mixColumns) accepts head block.
REQ-013 SHALL have port shiftRow_count_out  output  16  number of blocks delivered downstream, wraps.

Function
REQ-014 SHALL number bytes b0..b15 with b0 = data[127:120], bk = data[127-8k -: 8]; state s[r][c] = b(r+4c).
REQ-015 SHALL compute forward output s'[r][c] = s[r][(c+r) mod 4] for r,c in 0..3 (row 0 unchanged).
REQ-016 SHALL compute inverse output s'[r][c] = s[r][(c-r) mod 4] when shiftRow_inv_in=1 at acceptance.
REQ-017 SHALL accept a block (push) when shiftRow_valid_in=1, shiftRow_ready_out=1 and shiftRow_flush_in=0.
REQ-018 SHALL store the already-shifted state in the FIFO at push; the permutation is applied before storage.
REQ-019 SHALL drive shiftRow_ready_out = (occupancy < 2), from registered occupancy only, never from shiftRow_ready_in.
REQ-020 SHALL pop the head when shiftRow_valid_out=1 and shiftRow_ready_in=1 at a rising edge.
REQ-021 SHALL give latency 1: block pushed at edge N into empty FIFO is valid on output after edge N.
REQ-022 SHALL support push and pop in the same cycle at occupancy 1: occupancy stays 1, new block becomes head.
REQ-023 SHALL, at occupancy 2, refuse push (ready_out=0) even if a pop occurs that cycle.
REQ-024 SHALL hold shiftRow_data_out stable while valid_out=1 and ready_in=0.
REQ-025 SHALL preserve acceptance order (FIFO); no reordering or drops except by flush.
REQ-026 SHALL, when shiftRow_flush_in=1, set occupancy 0 at the edge, ignore push and pop, and not change count_out.
REQ-027 SHALL increment shiftRow_count_out by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL implement occupancy as a 2-bit counter with read/write pointers; values 0,1,2 only.

Reset
REQ-029 SHALL, on rst=0, immediately clear occupancy, pointers, count_out to 0, valid_out to 0, data_out to 0; ready_out=1 after reset.
REQ-030 SHALL, on reset mid-operation, discard all buffered blocks; no block is output after reset release unless pushed anew.
REQ-031 SHALL ignore all inputs while rst=0.

Verification
REQ-032 SHALL verify forward: push d42711aee0bf98f1b8b45de51e415230, inv=0, ready_in=1 -> next cycle valid_out=1, data_out d4bf5d30e0b452aeb84111f11e2798e5, count_out=1.
REQ-033 SHALL verify inverse: push d4bf5d30e0b452aeb84111f11e2798e5, inv=1 -> data_out d42711aee0bf98f1b8b45de51e415230.
REQ-034 SHALL verify backpressure: ready_in=0, push 3 consecutive blocks -> blocks 1,2 accepted, ready_out=0 on third, then ready_in=1 -> blocks 1,2 out in order, count_out=2.
REQ-035 SHALL verify simultaneous push/pop at occupancy 1 over 10 back-to-back blocks with ready_in=1 -> one block out per cycle, ready_out stays 1, count_out=10.
REQ-036 SHALL verify flush with occupancy 2 and valid_in=1 -> next cycle valid_out=0, ready_out=1, count_out unchanged.
REQ-037 SHALL verify async reset asserted mid-cycle with occupancy 2 -> valid_out=0, count_out=0 without a clock edge; count wrap after 65536 pops -> 0x0000.
